if_id_fetch_buffer: RTL and testbench

//  Instruction-fetch to decode boundary. Sits directly downstream of program_counter and instruction memory.

---
 rtl/riscv_pipe_pkg.sv | 13 +
 rtl/if_id_fetch_buffer.sv | 77 +++++++
 tb/tb_if_id_fetch_buffer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary.
package riscv_pipe_pkg;

    localparam int          PC_W      = 8;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_fetch_buffer.sv
// Small in-order FIFO between instruction fetch and decode; if_ready_o doubles as PC_Write.
module if_id_fetch_buffer
    import riscv_pipe_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int PC_W    = riscv_pipe_pkg::PC_W,
    parameter int INSTR_W = riscv_pipe_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    input  logic [PC_W-1:0]    if_pc,
    input  logic [INSTR_W-1:0] if_instr,
    output logic               if_ready,
    output logic               id_valid,
    output logic [PC_W-1:0]    id_pc,
    output logic [INSTR_W-1:0] id_instr,
    input  logic               id_ready,
    input  logic               flush
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               push, pop;

    // Ready depends on occupancy alone so the PC never waits on decode's handshake.
    assign if_ready = (count_q < CNT_W'(DEPTH));
    assign id_valid = (count_q != '0);
    assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign id_instr = id_valid ? instr_mem_q[rd_ptr_q] : INSTR_W'(NOP_INSTR);

    assign push = if_valid & if_ready & ~flush;
    assign pop  = id_valid & id_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is not reset: stale entries are masked by count_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]    <= if_pc;
                instr_mem_q[wr_ptr_q] <= if_instr;
            end
        end
    end

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Bench for if_id_fetch_buffer: queue scoreboard plus a table of hand-derived vectors.
module tb_if_id_fetch_buffer;
    import riscv_pipe_pkg::*;

    localparam int DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               if_valid;
    logic [PC_W-1:0]    if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic               if_ready;
    logic               id_valid;
    logic [PC_W-1:0]    id_pc;
    logic [INSTR_W-1:0] id_instr;
    logic               id_ready;
    logic               flush;

    int n_cmp  = 0;
    int n_fail = 0;

    if_id_entry_t sb_q[$];

    typedef struct {
        logic               v;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               idr;
        logic               fl;
        logic               exp_vld;
        logic [PC_W-1:0]    exp_pc;
        logic               exp_rdy;
    } vec_t;

    vec_t vecs[$];

    if_id_fetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_instr (id_instr),
        .id_ready (id_ready),
        .flush    (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against the scoreboard's current head and occupancy.
    task automatic chk_model(input string tag);
        logic [31:0] e_instr;
        logic [PC_W-1:0] e_pc;
        e_instr = (sb_q.size() != 0) ? sb_q[0].instr : NOP_INSTR;
        e_pc    = (sb_q.size() != 0) ? sb_q[0].pc : '0;
        chk({tag, ".id_valid"}, 32'(id_valid), 32'(sb_q.size() != 0));
        chk({tag, ".id_pc"},    32'(id_pc),    32'(e_pc));
        chk({tag, ".id_instr"}, id_instr,      e_instr);
        chk({tag, ".if_ready"}, 32'(if_ready), 32'(sb_q.size() < DEPTH));
    endtask

    task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                        input logic idr, input logic fl, input string tag);
        bit do_push, do_pop;
        if_valid = v;
        if_pc    = pc;
        if_instr = ins;
        id_ready = idr;
        flush    = fl;
        @(posedge clk);
        if (fl) begin
            sb_q.delete();
        end else begin
            do_pop  = (sb_q.size() != 0) && idr;
            do_push = v && (sb_q.size() < DEPTH);
            if (do_pop)  void'(sb_q.pop_front());
            if (do_push) sb_q.push_back('{pc: pc, instr: ins});
        end
        #1;
        chk_model(tag);
    endtask

    function automatic logic [31:0] mk_instr(input logic [PC_W-1:0] pc);
        return {8'hC0, 8'(pc), 16'h0093};
    endfunction

    initial begin
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_instr = '0;
        id_ready = 1'b0;
        flush    = 1'b0;

        // Streaming then stall/full; expected columns derived by hand.
        vecs.push_back('{1, 8'h00, 32'hA000_0001, 1, 0,  1, 8'h00, 1});
        vecs.push_back('{1, 8'h04, 32'hB000_0002, 1, 0,  1, 8'h04, 1});
        vecs.push_back('{1, 8'h08, 32'hC000_0003, 1, 0,  1, 8'h08, 1});
        vecs.push_back('{0, 8'h00, 32'h0,         1, 0,  0, 8'h00, 1});
        vecs.push_back('{1, 8'h10, 32'hD000_0004, 0, 0,  1, 8'h10, 1});
        vecs.push_back('{1, 8'h14, 32'hE000_0005, 0, 0,  1, 8'h10, 0});
        vecs.push_back('{1, 8'h18, 32'hF000_0006, 0, 0,  1, 8'h10, 0});
        vecs.push_back('{1, 8'h18, 32'hF000_0006, 1, 0,  1, 8'h14, 1});
        vecs.push_back('{0, 8'h00, 32'h0,         1, 0,  0, 8'h00, 1});

        // Reset asserted before any clock edge.
        #2;
        chk_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 8'h00, 32'h0, 0, 0, "idle");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].pc, vecs[i].instr, vecs[i].idr, vecs[i].fl, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_vld", i), 32'(id_valid), 32'(vecs[i].exp_vld));
            chk($sformatf("vec%0d.tbl_pc", i),  32'(id_pc),    32'(vecs[i].exp_pc));
            chk($sformatf("vec%0d.tbl_rdy", i), 32'(if_ready), 32'(vecs[i].exp_rdy));
        end

        // Flush with full buffer drops both entries and the concurrent push.
        step(1, 8'h30, mk_instr(8'h30), 0, 0, "fl_fill0");
        step(1, 8'h34, mk_instr(8'h34), 0, 0, "fl_fill1");
        step(1, 8'h40, mk_instr(8'h40), 1, 1, "flush");
        chk("flush.id_valid", 32'(id_valid), 32'd0);
        step(1, 8'h20, mk_instr(8'h20), 0, 0, "post_flush");
        chk("post_flush.id_pc", 32'(id_pc), 32'h20);
        step(0, 8'h00, 32'h0, 1, 0, "post_flush_pop");

        // Interleaved push/pop stalls so both pointers wrap several times.
        for (int i = 0; i < 14; i++)
            step((i % 3) != 2, 8'(8'h50 + 4 * i), mk_instr(8'(8'h50 + 4 * i)), (i % 4) != 1, 0,
                 $sformatf("wrap%0d", i));
        for (int i = 0; i < 3; i++) step(0, 8'h00, 32'h0, 1, 0, "drain");

        // Asynchronous reset between edges with two entries held.
        step(1, 8'h60, mk_instr(8'h60), 0, 0, "ar_fill0");
        step(1, 8'h64, mk_instr(8'h64), 0, 0, "ar_fill1");
        chk("ar.pre_rdy", 32'(if_ready), 32'd0);
        if_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk_model("async_rst");
        #1 rst_n = 1'b1;
        step(1, 8'h68, mk_instr(8'h68), 0, 0, "ar_recover");
        step(0, 8'h00, 32'h0, 1, 0, "ar_pop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
